// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clock-divider sequencer.
package clk_div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISABLE,
    LOAD,
    ENABLE,
    LOCK,
    DONE,
    ERR
  } state_t;

  // Lock timeout in ref-clock cycles: twice the largest representable ratio.
  function automatic int unsigned lock_timeout(input int unsigned ratio_width);
    return 32'd1 << (ratio_width + 1);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_edge_det.sv
// Rising-edge detector for the divided clock, sampled in the ref-clock domain.
module clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic cur;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider ratio-change sequencer: gate, settle, load, re-enable, confirm lock.
// Lock detection and timeout are present only when CLK_DIV_CTRL_LOCK_EN is defined.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_RATIO_WIDTH = 4,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned LOCK_EDGES      = 2
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  input  logic [DIV_RATIO_WIDTH-1:0] i_req_ratio,
  output logic                       o_req_ready,
  output logic                       o_div_clk_en,
  output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
  input  logic                       i_div_clk,
  output logic                       o_busy,
  output logic                       o_cfg_done,
  output logic                       o_cfg_err
);

  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [DIV_RATIO_WIDTH-1:0] MIN_DIV = DIV_RATIO_WIDTH'(2);

  state_t                     state, next_state;
  logic [DIV_RATIO_WIDTH-1:0] ratio_q;
  logic [SCW-1:0]             settle_cnt;
  logic                       en_q, en_d;
  logic                       fast_path;
  logic                       lock_ok;
  logic                       lock_tmo;

  // Nothing to do when the divider is already running the requested ratio.
  assign fast_path = (i_req_ratio == o_div_ratio) && (en_q == (i_req_ratio >= MIN_DIV));

`ifdef CLK_DIV_CTRL_LOCK_EN
  localparam int unsigned ECW = $clog2(LOCK_EDGES + 1);
  localparam logic [ECW-1:0] EDGE_LAST = ECW'(LOCK_EDGES - 1);
  localparam int unsigned TCW = DIV_RATIO_WIDTH + 1;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(lock_timeout(DIV_RATIO_WIDTH) - 1);

  logic           div_rise;
  logic [ECW-1:0] edge_cnt;
  logic [TCW-1:0] tmo_cnt;

  clk_edge_det u_edge_det (
    .clk  (i_ref_clk),
    .rst  (i_rst),
    .din  (i_div_clk),
    .rise (div_rise)
  );

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      edge_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (state != LOCK) begin
      edge_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (div_rise) edge_cnt <= edge_cnt + 1'b1;
      if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign lock_ok   = div_rise && (edge_cnt == EDGE_LAST);
  assign lock_tmo  = (tmo_cnt == TMO_LAST);
  assign o_cfg_err = (state == ERR);
`else
  logic unused_div_clk;
  assign unused_div_clk = i_div_clk;
  assign lock_ok        = 1'b0;
  assign lock_tmo       = 1'b0;
  assign o_cfg_err      = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (i_req_valid) next_state = fast_path ? DONE : DISABLE;
      DISABLE: if (settle_cnt == SETTLE_LAST) next_state = LOAD;
      LOAD:    next_state = (ratio_q < MIN_DIV) ? DONE : ENABLE;
`ifdef CLK_DIV_CTRL_LOCK_EN
      ENABLE:  next_state = LOCK;
`else
      ENABLE:  next_state = DONE;
`endif
      LOCK: begin
        if (lock_ok)       next_state = DONE;
        else if (lock_tmo) next_state = ERR;
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Enable is registered from the next state so it is valid in the state's first cycle
  // and holds its value through DONE/IDLE for the fast-path comparison.
  always_comb begin
    en_d = en_q;
    unique case (next_state)
      DISABLE, LOAD, ERR: en_d = 1'b0;
      ENABLE, LOCK:       en_d = 1'b1;
      default:            en_d = en_q;
    endcase
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      ratio_q     <= '0;
      o_div_ratio <= '0;
      settle_cnt  <= '0;
    end else begin
      state <= next_state;
      en_q  <= en_d;
      if (state == IDLE && i_req_valid) ratio_q <= i_req_ratio;
      if (state == LOAD) o_div_ratio <= ratio_q;
      if (state == DISABLE) settle_cnt <= settle_cnt + 1'b1;
      else                  settle_cnt <= '0;
    end
  end

  assign o_div_clk_en = en_q;
  assign o_req_ready  = (state == IDLE);
  assign o_busy       = (state != IDLE);
  assign o_cfg_done   = (state == DONE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with a behavioural divider and a stub feedback mode.
module tb_clk_div_ctrl;

  localparam int W = 4;
`ifdef CLK_DIV_CTRL_LOCK_EN
  localparam int RST_CYC = 5;
`else
  localparam int RST_CYC = 3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_ratio = '0;
  logic         req_ready, div_en, busy, cfg_done, cfg_err, div_clk;
  logic [W-1:0] div_ratio;

  logic         stub_mode = 1'b1;
  logic         stub_clk  = 1'b0;
  logic [W-1:0] dcnt;
  logic         dq;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic seen;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_RATIO_WIDTH (W),
    .SETTLE_CYCLES   (2),
    .LOCK_EDGES      (2)
  ) dut (
    .i_ref_clk    (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_ratio  (req_ratio),
    .o_req_ready  (req_ready),
    .o_div_clk_en (div_en),
    .o_div_ratio  (div_ratio),
    .i_div_clk    (div_clk),
    .o_busy       (busy),
    .o_cfg_done   (cfg_done),
    .o_cfg_err    (cfg_err)
  );

  // Behavioural integer divider: high for the upper half of each period, gated low when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
      dq   <= 1'b0;
    end else if (!div_en) begin
      dcnt <= '0;
      dq   <= 1'b0;
    end else if (dcnt == div_ratio - 1'b1) begin
      dcnt <= '0;
      dq   <= 1'b1;
    end else begin
      dcnt <= dcnt + 1'b1;
      if (dcnt + 1'b1 == (div_ratio >> 1)) dq <= 1'b0;
    end
  end

  assign div_clk = stub_mode ? stub_clk : (div_en ? dq : 1'b0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (cfg_done) seen = 1'b1;
      if (cfg_err) check("unexpected_err", 32'(cfg_err), 0);
    end
    check("done_within_budget", 32'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held.
    repeat (2) tick();
    check("rst_ready", 32'(req_ready), 1);
    check("rst_en",    32'(div_en),    0);
    check("rst_ratio", 32'(div_ratio), 0);
    check("rst_busy",  32'(busy),      0);
    check("rst_done",  32'(cfg_done),  0);
    check("rst_err",   32'(cfg_err),   0);
    rst = 1'b0;
    tick();

    // Full sequence to ratio 4 through the real divider.
    stub_mode = 1'b0;
    req_valid = 1'b1;
    req_ratio = 4'd4;
    tick();
    req_valid = 1'b0;
    req_ratio = 4'd9;
    check("r4_c1_en",    32'(div_en),    0);
    check("r4_c1_ready", 32'(req_ready), 0);
    check("r4_c1_busy",  32'(busy),      1);
    tick();
    check("r4_c2_en",    32'(div_en),    0);
    tick();
    check("r4_c3_ratio", 32'(div_ratio), 0);
    check("r4_c3_en",    32'(div_en),    0);
    tick();
    check("r4_c4_ratio", 32'(div_ratio), 4);
    check("r4_c4_en",    32'(div_en),    1);
`ifdef CLK_DIV_CTRL_LOCK_EN
    check("r4_c4_done",  32'(cfg_done),  0);
    wait_done(60);
`else
    tick();
    check("r4_c5_done",  32'(cfg_done),  1);
`endif
    tick();
    check("r4_post_done",  32'(cfg_done),  0);
    check("r4_post_ready", 32'(req_ready), 1);
    check("r4_post_en",    32'(div_en),    1);
    check("r4_post_ratio", 32'(div_ratio), 4);

    // Same ratio while running: immediate done, divider outputs untouched.
    req_valid = 1'b1;
    req_ratio = 4'd4;
    tick();
    req_valid = 1'b0;
    check("fast_c1_done",  32'(cfg_done),  1);
    check("fast_c1_en",    32'(div_en),    1);
    check("fast_c1_ratio", 32'(div_ratio), 4);
    check("fast_c1_ready", 32'(req_ready), 0);
    tick();
    check("fast_c2_done",  32'(cfg_done),  0);
    check("fast_c2_ready", 32'(req_ready), 1);
    check("fast_c2_en",    32'(div_en),    1);

    // Bypass ratio 1: enable drops and stays low, done at cycle 4.
    req_valid = 1'b1;
    req_ratio = 4'd1;
    tick();
    req_valid = 1'b0;
    check("byp_c1_en",    32'(div_en),    0);
    tick();
    check("byp_c2_en",    32'(div_en),    0);
    tick();
    check("byp_c3_ratio", 32'(div_ratio), 4);
    check("byp_c3_done",  32'(cfg_done),  0);
    tick();
    check("byp_c4_ratio", 32'(div_ratio), 1);
    check("byp_c4_en",    32'(div_en),    0);
    check("byp_c4_done",  32'(cfg_done),  1);
    tick();
    check("byp_c5_done",  32'(cfg_done),  0);
    check("byp_c5_ready", 32'(req_ready), 1);

    // Stub feedback held low: lock never seen.
    stub_mode = 1'b1;
    stub_clk  = 1'b0;
    req_valid = 1'b1;
    req_ratio = 4'd5;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("tmo_c4_en",    32'(div_en),    1);
    check("tmo_c4_ratio", 32'(div_ratio), 5);
`ifdef CLK_DIV_CTRL_LOCK_EN
    seen = 1'b0;
    for (cyc = 5; cyc <= 36; cyc++) begin
      tick();
      if (cfg_done || cfg_err) seen = 1'b1;
    end
    check("tmo_quiet_in_lock", 32'(seen), 0);
    tick();
    check("tmo_c37_err",   32'(cfg_err),   1);
    check("tmo_c37_done",  32'(cfg_done),  0);
    check("tmo_c37_en",    32'(div_en),    0);
    check("tmo_c37_ratio", 32'(div_ratio), 5);
    tick();
    check("tmo_c38_err",   32'(cfg_err),   0);
    check("tmo_c38_ready", 32'(req_ready), 1);
`else
    tick();
    check("nolock_c5_done", 32'(cfg_done), 1);
    check("nolock_c5_err",  32'(cfg_err),  0);
    tick();
    check("nolock_c6_ready", 32'(req_ready), 1);
`endif

    // Exact lock timing with hand-driven feedback edges.
    req_valid = 1'b1;
    req_ratio = 4'd6;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("stub_c4_ratio", 32'(div_ratio), 6);
    check("stub_c4_en",    32'(div_en),    1);
    tick();
`ifdef CLK_DIV_CTRL_LOCK_EN
    stub_clk = 1'b1;
    tick();
    check("stub_c6_done", 32'(cfg_done), 0);
    stub_clk = 1'b0;
    tick();
    check("stub_c7_done", 32'(cfg_done), 0);
    stub_clk = 1'b1;
    tick();
    check("stub_c8_done", 32'(cfg_done), 0);
    tick();
    check("stub_c9_done", 32'(cfg_done), 1);
    check("stub_c9_en",   32'(div_en),   1);
    stub_clk = 1'b0;
    tick();
    check("stub_c10_done", 32'(cfg_done), 0);
`else
    check("stub_c5_done", 32'(cfg_done), 1);
    tick();
`endif

    // Reset mid-sequence with the request held; it must restart cleanly afterwards.
    req_valid = 1'b1;
    req_ratio = 4'd3;
    tick();
    repeat (RST_CYC - 1) tick();
    check("mid_busy_before_rst", 32'(busy), 1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 1);
    check("mid_rst_en",    32'(div_en),    0);
    check("mid_rst_ratio", 32'(div_ratio), 0);
    check("mid_rst_busy",  32'(busy),      0);
    check("mid_rst_done",  32'(cfg_done),  0);
    check("mid_rst_err",   32'(cfg_err),   0);
    #1 rst = 1'b0;
    tick();
    req_valid = 1'b0;
    stub_mode = 1'b0;
    check("reacc_c1_busy",  32'(busy),      1);
    check("reacc_c1_ready", 32'(req_ready), 0);
    wait_done(60);
    check("reacc_ratio", 32'(div_ratio), 3);
    check("reacc_en",    32'(div_en),    1);
    tick();
    check("reacc_ready", 32'(req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
